// File: rtl/fifo_rr_merger.sv
// rtl/fifo_rr_merger.sv - round-robin merger of N FWFT source FIFOs onto one FIFO-style output
//
// Each grant emits one header word {4'hF, GRANT, seq[23:0]} followed by up to
// MAX_BURST data words taken straight from the granted source (no buffering).
//
// Ports:
//   BUS_CLK    clock, rising edge
//   BUS_RST_N  synchronous active-low reset
//   ENABLE     per-source enable; disabled sources are never granted
//   SRC_EMPTY  per-source empty flag
//   SRC_DATA   per-source word, source i at [32*i+31:32*i]
//   SRC_READ   per-source pop, combinational from OUT_READ during DATA
//   OUT_READ   consumer pop request
//   OUT_EMPTY  output empty flag
//   OUT_DATA   current output word
//   GRANT      index of the source owning the current/last burst
//   BUSY       high while a burst (header or data) is in progress
module fifo_rr_merger #(
  parameter int N         = 4,
  parameter int MAX_BURST = 16,
  parameter int SEQ_BITS  = 24
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST_N,
  input  logic [N-1:0]    ENABLE,
  input  logic [N-1:0]    SRC_EMPTY,
  input  logic [32*N-1:0] SRC_DATA,
  output logic [N-1:0]    SRC_READ,
  input  logic            OUT_READ,
  output logic            OUT_EMPTY,
  output logic [31:0]     OUT_DATA,
  output logic [3:0]      GRANT,
  output logic            BUSY
);

  typedef enum logic [1:0] {
    ST_ARB,
    ST_HEADER,
    ST_DATA
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(MAX_BURST - 1);

  state_t              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          last_q, last_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [SEQ_BITS-1:0] seq_q, seq_d;

  logic [N-1:0]        cand;
  logic                found;
  logic [3:0]          pick;

  logic                sel_empty;
  logic                sel_enable;
  logic [31:0]         sel_data;
  logic [23:0]         seq_field;

  logic                out_empty;
  logic [31:0]         out_data;
  logic [N-1:0]        src_read;

  // Header carries exactly 24 sequence bits: zero-extend narrow counters,
  // drop the top bits of wide ones.
  generate
    if (SEQ_BITS >= 24) begin : g_seq_trunc
      assign seq_field = seq_q[23:0];
    end else begin : g_seq_pad
      assign seq_field = {{(24 - SEQ_BITS){1'b0}}, seq_q};
    end
  endgenerate

  assign cand = ENABLE & ~SRC_EMPTY;

  // Rotating priority: distance 1 from the last grant wins first, so the
  // source that just finished is considered last.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && cand[i] && (((int'(last_q) + k) % N) == i)) begin
          found = 1'b1;
          pick  = 4'(i);
        end
      end
    end
  end

  // Mux of the granted source; grant_q is always < N outside reset.
  always_comb begin
    sel_empty  = 1'b1;
    sel_enable = 1'b0;
    sel_data   = 32'h0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == 4'(i)) begin
        sel_empty  = SRC_EMPTY[i];
        sel_enable = ENABLE[i];
        sel_data   = SRC_DATA[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    out_empty = 1'b1;
    out_data  = 32'h0;
    src_read  = '0;

    case (state_q)
      ST_ARB: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          cnt_d   = 16'd0;
          state_d = ST_HEADER;
        end
      end

      // Header is owed once granted, regardless of what the source does next.
      ST_HEADER: begin
        out_empty = 1'b0;
        out_data  = {4'hF, grant_q, seq_field};
        if (OUT_READ) begin
          seq_d   = seq_q + SEQ_BITS'(1);
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        out_empty = sel_empty | ~sel_enable;
        out_data  = sel_data;
        if (OUT_READ && !out_empty) begin
          for (int i = 0; i < N; i++) begin
            if (grant_q == 4'(i)) src_read[i] = 1'b1;
          end
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) state_d = ST_ARB;
        end else if (out_empty) begin
          // A stalled (empty or disabled) source gives up the output.
          state_d = ST_ARB;
        end
      end

      default: state_d = ST_ARB;
    endcase

    // While reset is held nothing may be popped and the output looks idle.
    if (!BUS_RST_N) begin
      out_empty = 1'b1;
      out_data  = 32'h0;
      src_read  = '0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q <= ST_ARB;
      grant_q <= 4'd0;
      last_q  <= 4'(N - 1);
      cnt_q   <= 16'd0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
    end
  end

  assign OUT_EMPTY = out_empty;
  assign OUT_DATA  = out_data;
  assign SRC_READ  = src_read;
  assign GRANT     = grant_q;
  assign BUSY      = BUS_RST_N && (state_q != ST_ARB);

endmodule

// File: tb/tb_fifo_rr_merger.sv
// tb/tb_fifo_rr_merger.sv - directed self-checking bench for fifo_rr_merger
module tb_fifo_rr_merger;

  localparam int N  = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    enable;
  logic [N-1:0]    src_empty;
  logic [32*N-1:0] src_data;
  logic [N-1:0]    src_read;
  logic            out_read;
  logic            out_empty;
  logic [31:0]     out_data;
  logic [3:0]      grant;
  logic            busy;

  always #5 clk = ~clk;

  fifo_rr_merger #(.N(N), .MAX_BURST(MB), .SEQ_BITS(24)) dut (
    .BUS_CLK   (clk),
    .BUS_RST_N (rst_n),
    .ENABLE    (enable),
    .SRC_EMPTY (src_empty),
    .SRC_DATA  (src_data),
    .SRC_READ  (src_read),
    .OUT_READ  (out_read),
    .OUT_EMPTY (out_empty),
    .OUT_DATA  (out_data),
    .GRANT     (grant),
    .BUSY      (busy)
  );

  // Source FIFO models (first-word-fall-through).
  logic [31:0] mem [N][64];
  int wr_ptr [N] = '{default: 0};
  int rd_ptr [N] = '{default: 0};

  always_comb begin
    src_empty = '1;
    src_data  = '0;
    for (int i = 0; i < N; i++) begin
      src_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
      src_data[32*i +: 32] = mem[i][rd_ptr[i] % 64];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (src_read[i] === 1'b1) rd_ptr[i] <= rd_ptr[i] + 1;
  end

  int vectors = 0;
  int miscompares = 0;
  int pulses [N];
  int illegal;
  int busy_cycles;
  int saved_rd;
  logic [31:0] out_q[$];
  logic [31:0] exp_q[$];

  task automatic push(input int s, input logic [31:0] w);
    mem[s][wr_ptr[s] % 64] = w;
    wr_ptr[s] = wr_ptr[s] + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) pulses[i] = 0;
    illegal = 0;
    busy_cycles = 0;
  endtask

  // One clock: drive OUT_READ, then sample away from the edge.
  task automatic step(input logic rd);
    @(negedge clk);
    out_read = rd;
    #1;
    if (busy) busy_cycles++;
    if (src_read != '0) begin
      if (!(out_read && !out_empty)) illegal++;
      if (src_read != (4'b0001 << grant)) illegal++;
    end
    if (out_read && !out_empty) out_q.push_back(out_data);
    for (int i = 0; i < N; i++) if (src_read[i]) pulses[i]++;
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < out_q.size()) chk($sformatf("%s[%0d]", tag, i), out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rem [N];
    int seqv;
    int n;

    // ---- reset then idle ----
    rst_n = 1'b0;
    enable = '1;
    out_read = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_empty", 32'(out_empty), 32'd1);
    chk("rst_src_read", 32'(src_read), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    clear_stats();
    repeat (100) step(1'b1);
    chk("idle_busy_cycles", 32'(busy_cycles), 32'd0);
    chk("idle_pops", 32'(out_q.size()), 32'd0);

    // ---- single source, burst ends on empty ----
    clear_stats();
    for (int k = 0; k < 3; k++) push(2, 32'h200 + 32'(k));
    repeat (10) step(1'b1);
    exp_q = '{32'hF200_0000, 32'h200, 32'h201, 32'h202};
    compare_stream("single");
    chk("single_pulses2", 32'(pulses[2]), 32'd3);
    chk("single_pulses_other", 32'(pulses[0] + pulses[1] + pulses[3]), 32'd0);
    push(2, 32'h2AA);
    repeat (8) step(1'b1);
    exp_q = '{32'hF200_0001, 32'h2AA};
    compare_stream("single_next");
    chk("single_legal", 32'(illegal), 32'd0);

    // ---- round robin with burst limit ----
    do_reset();
    clear_stats();
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < 10; k++) push(s, 32'h0A00_0000 | (32'(s) << 8) | 32'(k));
      rem[s] = 10;
    end
    seqv = 0;
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < N; s++) begin
        exp_q.push_back({4'hF, 4'(s), 24'(seqv)});
        seqv++;
        n = (rem[s] < MB) ? rem[s] : MB;
        for (int j = 0; j < n; j++)
          exp_q.push_back(32'h0A00_0000 | (32'(s) << 8) | 32'(10 - rem[s] + j));
        rem[s] = rem[s] - n;
      end
    end
    repeat (100) step(1'b1);
    compare_stream("rr");
    push(0, 32'h0000_00AB);
    repeat (8) step(1'b1);
    exp_q = '{32'hF000_000C, 32'h0000_00AB};
    compare_stream("rr_seq");
    chk("rr_legal", 32'(illegal), 32'd0);

    // ---- backpressure ----
    clear_stats();
    for (int k = 0; k < 4; k++) push(1, 32'hB0 + 32'(k));
    for (int i = 0; i < 20; i++) step((i % 2) == 0);
    exp_q = '{32'hF100_000D, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
    compare_stream("bp");
    chk("bp_pulses1", 32'(pulses[1]), 32'd4);
    chk("bp_legal", 32'(illegal), 32'd0);

    // ---- disable mid-burst ----
    clear_stats();
    for (int k = 0; k < 4; k++) push(1, 32'hC0 + 32'(k));
    for (int i = 0; i < 12 && out_q.size() < 3; i++) step(1'b1);
    @(negedge clk);
    enable = 4'b1101;
    out_read = 1'b1;
    #1;
    chk("dis_out_empty", 32'(out_empty), 32'd1);
    chk("dis_src_read", 32'(src_read), 32'd0);
    chk("dis_busy", 32'(busy), 32'd1);
    push(3, 32'hD0);
    push(3, 32'hD1);
    repeat (9) step(1'b1);
    exp_q = '{32'hF100_000E, 32'hC0, 32'hC1, 32'hF300_000F, 32'hD0, 32'hD1};
    compare_stream("dis");
    chk("dis_src1_left", 32'(wr_ptr[1] - rd_ptr[1]), 32'd2);
    chk("dis_pulses1", 32'(pulses[1]), 32'd2);
    enable = '1;
    repeat (8) step(1'b1);
    exp_q = '{32'hF100_0010, 32'hC2, 32'hC3};
    compare_stream("reen");
    chk("dis_legal", 32'(illegal), 32'd0);

    // ---- reset mid-burst ----
    clear_stats();
    for (int k = 0; k < 4; k++) push(3, 32'hE0 + 32'(k));
    push(0, 32'hF0);
    for (int i = 0; i < 12 && out_q.size() < 2; i++) step(1'b1);
    exp_q = '{32'hF300_0011, 32'hE0};
    compare_stream("prerst");
    @(negedge clk);
    rst_n = 1'b0;
    out_read = 1'b1;
    #1;
    chk("mrst_src_read", 32'(src_read), 32'd0);
    chk("mrst_out_empty", 32'(out_empty), 32'd1);
    chk("mrst_out_data", out_data, 32'h0);
    chk("mrst_busy", 32'(busy), 32'd0);
    saved_rd = rd_ptr[3];
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_no_pop", 32'(rd_ptr[3]), 32'(saved_rd));
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_src3_left", 32'(wr_ptr[3] - rd_ptr[3]), 32'd3);
    repeat (4) step(1'b1);
    exp_q = '{32'hF000_0000, 32'hF0};
    compare_stream("postrst");
    chk("rst_legal", 32'(illegal), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
